// File: rtl/pipe_defs.sv
// Shared definitions for the hazard controller: forward-select encoding
// and the bit layout of one pipeline tracking slot {valid, regwrite, wa, isload}.
package pipe_defs;

  localparam int SEL_RF      = 0;
  localparam int SLOT_ISLOAD = 0;
  localparam int SLOT_WA_LSB = 1;

  // Slot width and upper field positions depend on the register-address width.
  function automatic int slot_width(input int regw);
    return regw + 3;
  endfunction

  function automatic int slot_regwrite_bit(input int regw);
    return regw + 1;
  endfunction

  function automatic int slot_valid_bit(input int regw);
    return regw + 2;
  endfunction

endpackage

// File: rtl/operand_hazard_match.sv
// Match/priority logic for one source operand against all tracked stages:
// the youngest matching producer wins, and a too-young load becomes a hazard.
module operand_hazard_match
  import pipe_defs::*;
#(
  parameter int NSTAGE   = 3,
  parameter int REGW     = 5,
  parameter int LOAD_RDY = 2,
  localparam int SLOTW   = slot_width(REGW),
  localparam int SELW    = $clog2(NSTAGE + 1)
) (
  input  logic                          use_op,
  input  logic [REGW-1:0]               op_reg,
  input  logic [NSTAGE-1:0][SLOTW-1:0]  slots,
  output logic                          hazard,
  output logic [SELW-1:0]               sel
);

  localparam int VALID_BIT    = slot_valid_bit(REGW);
  localparam int REGWRITE_BIT = slot_regwrite_bit(REGW);

  logic [NSTAGE-1:0] match;

  // Register 0 is hardwired, so it never matches a producer.
  always_comb begin
    match = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      match[k] = use_op && (op_reg != '0) && slots[k][VALID_BIT] &&
                 slots[k][REGWRITE_BIT] &&
                 (slots[k][SLOT_WA_LSB +: REGW] == op_reg);
    end
  end

  // Scan oldest to youngest so the lowest-indexed match is the last one written.
  always_comb begin
    hazard = 1'b0;
    sel    = SELW'(SEL_RF);
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (match[k]) begin
        if (slots[k][SLOT_ISLOAD] && (k + 1 < LOAD_RDY)) begin
          hazard = 1'b1;
          sel    = SELW'(SEL_RF);
        end else begin
          hazard = 1'b0;
          sel    = SELW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks destination writes in the stages after ID,
// selects forwarding sources, raises load-use stalls and redirect flushes.
module pipe_hazard_ctrl
  import pipe_defs::*;
#(
  parameter int NSTAGE   = 3,
  parameter int REGW     = 5,
  parameter int LOAD_RDY = 2,
  parameter int CNTW     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REGW-1:0]               id_rs,
  input  logic [REGW-1:0]               id_rt,
  input  logic                          id_use_rs,
  input  logic                          id_use_rt,
  input  logic                          id_regwrite,
  input  logic [REGW-1:0]               id_wa,
  input  logic                          id_isload,
  input  logic                          redirect,
  output logic                          stall,
  output logic                          flush,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_sel,
  output logic [NSTAGE-1:0]             stage_valid,
  output logic [CNTW-1:0]               stall_cnt,
  output logic [CNTW-1:0]               flush_cnt
);

  localparam int SLOTW        = slot_width(REGW);
  localparam int VALID_BIT    = slot_valid_bit(REGW);
  localparam int REGWRITE_BIT = slot_regwrite_bit(REGW);

  if (NSTAGE < 2 || LOAD_RDY < 1 || LOAD_RDY > NSTAGE) begin : g_bad_params
    $error("pipe_hazard_ctrl: need NSTAGE >= 2 and 1 <= LOAD_RDY <= NSTAGE");
  end

  logic [NSTAGE-1:0][SLOTW-1:0] slot_q;
  logic [SLOTW-1:0]             id_slot;
  logic                         rs_hazard;
  logic                         rt_hazard;

  always_comb begin
    id_slot                          = '0;
    id_slot[VALID_BIT]               = id_valid;
    id_slot[REGWRITE_BIT]            = id_regwrite;
    id_slot[SLOT_WA_LSB +: REGW]     = id_wa;
    id_slot[SLOT_ISLOAD]             = id_isload;
  end

  operand_hazard_match #(
    .NSTAGE   (NSTAGE),
    .REGW     (REGW),
    .LOAD_RDY (LOAD_RDY)
  ) u_rs_match (
    .use_op (id_use_rs),
    .op_reg (id_rs),
    .slots  (slot_q),
    .hazard (rs_hazard),
    .sel    (fwd_rs_sel)
  );

  operand_hazard_match #(
    .NSTAGE   (NSTAGE),
    .REGW     (REGW),
    .LOAD_RDY (LOAD_RDY)
  ) u_rt_match (
    .use_op (id_use_rt),
    .op_reg (id_rt),
    .slots  (slot_q),
    .hazard (rt_hazard),
    .sel    (fwd_rt_sel)
  );

  // A redirect kills the ID instruction anyway, so it overrides any stall.
  assign flush = redirect;
  assign stall = ~reset & id_valid & (rs_hazard | rt_hazard) & ~redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q[0] <= (stall || flush) ? '0 : id_slot;
      for (int k = 1; k < NSTAGE; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      stage_valid[k] = slot_q[k][VALID_BIT];
    end
  end

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table walks the pipeline through
// forwarding and hazard cases, plus sequences for reset, flush and saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, id_regwrite, id_isload, redirect;
  logic [4:0]  id_rs, id_rt, id_wa;

  logic        stall, flush;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [2:0]  stage_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall2, flush2;
  logic [2:0]  fwd_rs_sel2, fwd_rt_sel2;
  logic [5:0]  stage_valid2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, rw;
    logic [4:0] wa;
    logic       ld, redir;
    logic       es, ef;
    logic [1:0] efs, eft;
    logic [2:0] esv;
  } vec_t;

  vec_t vecs[13];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
    .id_wa(id_wa), .id_isload(id_isload), .redirect(redirect), .stall(stall),
    .flush(flush), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Deep pipe with late load readiness and a tiny counter, for saturation.
  pipe_hazard_ctrl #(.NSTAGE(6), .REGW(5), .LOAD_RDY(6), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
    .id_wa(id_wa), .id_isload(id_isload), .redirect(redirect), .stall(stall2),
    .flush(flush2), .fwd_rs_sel(fwd_rs_sel2), .fwd_rt_sel(fwd_rt_sel2),
    .stage_valid(stage_valid2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs,
                              logic urt, logic rw, logic [4:0] wa, logic ld,
                              logic redir, logic es, logic ef, logic [1:0] efs,
                              logic [1:0] eft, logic [2:0] esv);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rw = rw;
    r.wa = wa; r.ld = ld; r.redir = redir; r.es = es; r.ef = ef;
    r.efs = efs; r.eft = eft; r.esv = esv;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t t);
    id_valid    = t.v;
    id_rs       = t.rs;
    id_rt       = t.rt;
    id_use_rs   = t.urs;
    id_use_rt   = t.urt;
    id_regwrite = t.rw;
    id_wa       = t.wa;
    id_isload   = t.ld;
    redirect    = t.redir;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // v  rs  rt urs urt rw wa ld rd | st fl fs ft sv
    vecs[0]  = mk(1, 0,  0,  0, 0, 1, 8,  1, 0,  0, 0, 0, 0, 3'b000);
    vecs[1]  = mk(1, 8,  3,  1, 1, 1, 10, 0, 0,  1, 0, 0, 0, 3'b001);
    vecs[2]  = mk(1, 8,  3,  1, 1, 1, 10, 0, 0,  0, 0, 2, 0, 3'b010);
    vecs[3]  = mk(1, 10, 8,  1, 1, 1, 9,  0, 0,  0, 0, 1, 3, 3'b101);
    vecs[4]  = mk(1, 9,  10, 1, 1, 1, 9,  0, 0,  0, 0, 1, 2, 3'b011);
    vecs[5]  = mk(1, 10, 9,  1, 1, 1, 0,  1, 0,  0, 0, 3, 1, 3'b111);
    vecs[6]  = mk(1, 0,  0,  1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 3'b111);
    vecs[7]  = mk(1, 9,  9,  0, 1, 1, 12, 1, 0,  0, 0, 0, 3, 3'b111);
    vecs[8]  = mk(1, 12, 0,  1, 1, 1, 13, 1, 1,  0, 1, 0, 0, 3'b111);
    vecs[9]  = mk(1, 13, 12, 1, 1, 0, 0,  0, 0,  0, 0, 0, 2, 3'b110);
    vecs[10] = mk(0, 0,  0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 3'b101);
    vecs[11] = mk(1, 0,  0,  0, 0, 1, 5,  1, 0,  0, 0, 0, 0, 3'b010);
    vecs[12] = mk(0, 5,  0,  1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 3'b101);

    reset = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    #3;
    checkOutput("reset stall", 32'(stall), 0);
    checkOutput("reset flush", 32'(flush), 0);
    checkOutput("reset fwd_rs", 32'(fwd_rs_sel), 0);
    checkOutput("reset fwd_rt", 32'(fwd_rt_sel), 0);
    checkOutput("reset stage_valid", 32'(stage_valid), 0);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 0);
    checkOutput("reset flush_cnt", 32'(flush_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].es));
      checkOutput($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].ef));
      checkOutput($sformatf("v%0d fwd_rs", i), 32'(fwd_rs_sel), 32'(vecs[i].efs));
      checkOutput($sformatf("v%0d fwd_rt", i), 32'(fwd_rt_sel), 32'(vecs[i].eft));
      checkOutput($sformatf("v%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].esv));
      @(posedge clk);
      #1;
    end
    checkOutput("stall_cnt after table", 32'(stall_cnt), 1);
    checkOutput("flush_cnt after table", 32'(flush_cnt), 1);

    // Reset dropped in the middle of a load-use stall.
    applyStimulus(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0, 3'b000));
    @(posedge clk);
    #1;
    applyStimulus(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    @(negedge clk);
    checkOutput("pre-reset stall", 32'(stall), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid-reset stall", 32'(stall), 0);
    checkOutput("mid-reset stage_valid", 32'(stage_valid), 0);
    checkOutput("mid-reset fwd_rs", 32'(fwd_rs_sel), 0);
    checkOutput("mid-reset stall_cnt", 32'(stall_cnt), 0);
    checkOutput("mid-reset flush_cnt", 32'(flush_cnt), 0);
    redirect = 1'b1;
    #1;
    checkOutput("in-reset flush", 32'(flush), 1);
    checkOutput("in-reset stall", 32'(stall), 0);
    redirect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post-reset stall", 32'(stall), 0);

    // Deep-pipe instance: five back-to-back stalls against a 2-bit counter.
    applyStimulus(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0, 3'b000));
    @(posedge clk);
    #1;
    applyStimulus(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sat stall c%0d", i), 32'(stall2), 1);
      checkOutput($sformatf("sat cnt c%0d", i), 32'(stall_cnt2), (i < 3) ? i : 3);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("sat stall released", 32'(stall2), 0);
    checkOutput("sat fwd_rs deep", 32'(fwd_rs_sel2), 6);
    checkOutput("sat cnt end", 32'(stall_cnt2), 3);
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    @(negedge clk);
    checkOutput("sat cnt hold", 32'(stall_cnt2), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
